// File: rtl/color_classifier.sv
// Colour-sensor sequencer: steps the filter through R/G/B, captures the counter result per channel, classifies.
// Optional MEASURE watchdog and sticky timeout_err port when COLOR_TIMEOUT_EN is defined.
module color_classifier #(
  parameter int SETTLE_CYCLES  = 10000,
  parameter int MIN_FREQ       = 1000
`ifdef COLOR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 600000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [17:0] frequency,
  input  logic        flag_done,
  output logic        cs_state,
  output logic        done_flag,
  output logic        s2,
  output logic        s3,
  output logic [17:0] red_freq,
  output logic [17:0] green_freq,
  output logic [17:0] blue_freq,
  output logic [1:0]  color,
  output logic        valid,
`ifdef COLOR_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        busy
);

  // state    | meaning
  // IDLE     | waiting for start, counter disabled
  // SELECT   | filter driven for current channel, settle countdown
  // MEASURE  | counter enabled, waiting for flag_done
  // CAPTURE  | one cycle, counter cleared via done_flag
  // CLASSIFY | one cycle, color/valid updated
  typedef enum logic [2:0] {IDLE, SELECT, MEASURE, CAPTURE, CLASSIFY} state_e;
  typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE} chan_e;

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
  localparam logic [17:0] MIN_F = 18'(MIN_FREQ);

  state_e        state_q;
  chan_e         chan_q;
  logic [SW-1:0] settle_q;
  logic          cs_state_q, done_flag_q, s2_q, s3_q, valid_q, busy_q;
  logic [17:0]   red_q, green_q, blue_q;
  logic [1:0]    color_q, color_d;
  logic          store_en;
  logic [17:0]   store_val;

`ifdef COLOR_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wdog_q;
  logic          timeout_q;
  logic          timeout_hit;
`endif

  function automatic logic [1:0] chan_sel(input chan_e c);
    case (c)
      CH_GREEN: chan_sel = 2'b11;
      CH_BLUE:  chan_sel = 2'b01;
      default:  chan_sel = 2'b00;
    endcase
  endfunction

  // Winner must strictly beat both others and reach MIN_FREQ.
  always_comb begin
    color_d = 2'b00;
    if (red_q > green_q && red_q > blue_q && red_q >= MIN_F)
      color_d = 2'b01;
    else if (green_q > red_q && green_q > blue_q && green_q >= MIN_F)
      color_d = 2'b10;
    else if (blue_q > red_q && blue_q > green_q && blue_q >= MIN_F)
      color_d = 2'b11;
  end

  always_comb begin
    store_en  = 1'b0;
    store_val = frequency;
`ifdef COLOR_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    if (state_q == MEASURE) begin
      if (flag_done) begin
        store_en = 1'b1;
`ifdef COLOR_TIMEOUT_EN
      end else if (wdog_q == '0) begin
        store_en    = 1'b1;
        store_val   = '0;
        timeout_hit = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      chan_q      <= CH_RED;
      settle_q    <= '0;
      cs_state_q  <= 1'b0;
      done_flag_q <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      color_q     <= 2'b00;
`ifdef COLOR_TIMEOUT_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      done_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= SELECT;
            chan_q       <= CH_RED;
            {s2_q, s3_q} <= chan_sel(CH_RED);
            settle_q     <= SETTLE_LD;
            busy_q       <= 1'b1;
`ifdef COLOR_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        SELECT: begin
          if (settle_q == '0) begin
            state_q    <= MEASURE;
            cs_state_q <= 1'b1;
`ifdef COLOR_TIMEOUT_EN
            wdog_q     <= TO_LD;
`endif
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        MEASURE: begin
          // Counter clears frequency once cs_state drops, so capture this cycle.
          if (store_en) begin
            case (chan_q)
              CH_RED:   red_q   <= store_val;
              CH_GREEN: green_q <= store_val;
              default:  blue_q  <= store_val;
            endcase
            state_q     <= CAPTURE;
            cs_state_q  <= 1'b0;
            done_flag_q <= 1'b1;
`ifdef COLOR_TIMEOUT_EN
            if (timeout_hit) timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q - 1'b1;
`endif
          end
        end
        CAPTURE: begin
          if (chan_q == CH_BLUE) begin
            state_q <= CLASSIFY;
            color_q <= color_d;
            valid_q <= 1'b1;
          end else begin
            state_q  <= SELECT;
            settle_q <= SETTLE_LD;
            if (chan_q == CH_RED) begin
              chan_q       <= CH_GREEN;
              {s2_q, s3_q} <= chan_sel(CH_GREEN);
            end else begin
              chan_q       <= CH_BLUE;
              {s2_q, s3_q} <= chan_sel(CH_BLUE);
            end
          end
        end
        CLASSIFY: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          cs_state_q <= 1'b0;
        end
      endcase
    end
  end

  assign cs_state   = cs_state_q;
  assign done_flag  = done_flag_q;
  assign s2         = s2_q;
  assign s3         = s3_q;
  assign red_freq   = red_q;
  assign green_freq = green_q;
  assign blue_freq  = blue_q;
  assign color      = color_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
`ifdef COLOR_TIMEOUT_EN
  assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_color_classifier.sv
// Scoreboard bench for color_classifier with a behavioural frequency-counter model.
// Timeout scenario is exercised only when COLOR_TIMEOUT_EN is defined.
module tb_color_classifier;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] frequency = '0;
  logic        flag_done = 1'b0;
  logic        cs_state, done_flag, s2, s3, valid, busy;
  logic [17:0] red_freq, green_freq, blue_freq;
  logic [1:0]  color;
`ifdef COLOR_TIMEOUT_EN
  logic        timeout_err;
`endif

  color_classifier #(
    .SETTLE_CYCLES(4),
    .MIN_FREQ(1000)
`ifdef COLOR_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .frequency(frequency), .flag_done(flag_done),
    .cs_state(cs_state), .done_flag(done_flag), .s2(s2), .s3(s3),
    .red_freq(red_freq), .green_freq(green_freq), .blue_freq(blue_freq),
    .color(color), .valid(valid),
`ifdef COLOR_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  c;
    logic [17:0] r, g, b;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] seq_q[$];
  int total = 0, bad = 0;
  int valid_cnt = 0, df_hi = 0, df_rise = 0;
  logic cs_prev = 1'b0, df_prev = 1'b0;

  logic [17:0] val_r = '0, val_g = '0, val_b = '0;
  logic        hang_green = 1'b0;
  int          mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Counter model: result appears 20 cycles after cs_state rises.
  always @(posedge clock) begin
    #1;
    flag_done = 1'b0;
    frequency = '0;
    if (!cs_state) begin
      mcnt = 0;
    end else begin
      if (mcnt == 19 && !(hang_green && s2 && s3)) begin
        flag_done = 1'b1;
        case ({s2, s3})
          2'b00:   frequency = val_r;
          2'b11:   frequency = val_g;
          default: frequency = val_b;
        endcase
      end
      mcnt++;
    end
  end

  always @(negedge clock) begin
    if (valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("color", 64'(color), 64'(e.c));
        chk("red_freq", 64'(red_freq), 64'(e.r));
        chk("green_freq", 64'(green_freq), 64'(e.g));
        chk("blue_freq", 64'(blue_freq), 64'(e.b));
      end
    end
    if (cs_state && !cs_prev) seq_q.push_back({s2, s3});
    if (done_flag) df_hi++;
    if (done_flag && !df_prev) df_rise++;
    cs_prev = cs_state;
    df_prev = done_flag;
  end

  task automatic push_exp(input logic [1:0] c, input logic [17:0] r, g, b);
    exp_t e;
    e.c = c; e.r = r; e.g = g; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (valid) got = 1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic run(input string name, input logic [17:0] r, g, b, input logic [1:0] c);
    val_r = r; val_g = g; val_b = b;
    push_exp(c, r, g, b);
    pulse_start();
    wait_valid(name);
    @(negedge clock);
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cs_state, done_flag, s2, s3, red_freq, green_freq, blue_freq, color, valid, busy});
  endfunction

  initial begin
    int v0;
    bit hit;
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clock) reset_n = 1'b1;

    seq_q.delete(); df_hi = 0; df_rise = 0; v0 = valid_cnt;
    run("nominal_red", 18'd5000, 18'd2000, 18'd1500, 2'b01);
    chk("seq_len", 64'(seq_q.size()), 64'd3);
    if (seq_q.size() == 3) begin
      chk("seq_red", 64'(seq_q[0]), 64'b00);
      chk("seq_green", 64'(seq_q[1]), 64'b11);
      chk("seq_blue", 64'(seq_q[2]), 64'b01);
    end
    chk("done_flag_cycles", 64'(df_hi), 64'd3);
    chk("done_flag_pulses", 64'(df_rise), 64'd3);
    chk("nominal_valid_count", 64'(valid_cnt - v0), 64'd1);

    run("below_min", 18'd800, 18'd600, 18'd500, 2'b00);
    run("tie", 18'd4000, 18'd4000, 18'd100, 2'b00);

    v0 = valid_cnt;
    val_r = 18'd1000; val_g = 18'd1000; val_b = 18'd9000;
    push_exp(2'b11, 18'd1000, 18'd1000, 18'd9000);
    pulse_start();
    repeat (30) @(negedge clock);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_valid("blue_valid");
    repeat (20) @(negedge clock);
    chk("blue_no_restart", 64'(busy), 64'd0);
    chk("blue_valid_count", 64'(valid_cnt - v0), 64'd1);

    val_r = 18'd7000; val_g = 18'd100; val_b = 18'd100;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clock);
      if (cs_state && s2 && s3) hit = 1;
    end
    chk("reach_green_measure", 64'(hit), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("midrun_reset_outputs", all_outs(), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    run("after_reset", 18'd1200, 18'd2500, 18'd2400, 2'b10);

`ifdef COLOR_TIMEOUT_EN
    hang_green = 1'b1;
    run("timeout_run", 18'd2000, 18'd0, 18'd3000, 2'b11);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    hang_green = 1'b0;
    val_g = 18'd500;
    push_exp(2'b11, 18'd2000, 18'd500, 18'd3000);
    pulse_start();
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
    wait_valid("timeout_next_valid");
    @(negedge clock);
`endif

    v0 = valid_cnt;
    val_r = 18'd100; val_g = 18'd3000; val_b = 18'd2999;
    push_exp(2'b10, 18'd100, 18'd3000, 18'd2999);
    push_exp(2'b10, 18'd100, 18'd3000, 18'd2999);
    @(negedge clock) start = 1'b1;
    wait_valid("b2b_first_valid");
    @(negedge clock);
    chk("b2b_idle", 64'(busy), 64'd0);
    @(negedge clock);
    chk("b2b_restart", 64'(busy), 64'd1);
    start = 1'b0;
    wait_valid("b2b_second_valid");
    @(negedge clock);
    chk("b2b_busy_low", 64'(busy), 64'd0);
    repeat (5) @(negedge clock);
    chk("b2b_valid_count", 64'(valid_cnt - v0), 64'd2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/color_classifier.md
# color_classifier

Sequencer and classifier directly downstream of the frequency counter in the rover's colour-sensing path. It steps the colour sensor's photodiode filter through red, green and blue, and enables the counter for each channel. It captures each `frequency` result on `flag_done`, then classifies the object colour from the three captured frequencies. Results go to the rover's navigation control.

## Interface
Parameters:
- `SETTLE_CYCLES`, 10000: clock cycles to wait after changing S2/S3 before enabling the counter.
- `MIN_FREQ`, 1000: minimum winning-channel frequency (Hz); below this the result is "none".
- `TIMEOUT_CYCLES`, 600000: MEASURE watchdog limit; used only with `COLOR_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock (Basys board clock).
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  measurement request; sampled only in IDLE.
- `frequency`  in  18  result from the frequency counter, in Hz.
- `flag_done`  in  1  counter result-ready flag.
- `cs_state`  out  1  counter enable; drives the counter's `CS_state`.
- `done_flag`  out  1  counter clear pulse; drives the counter's `done_flag`.
- `s2`, `s3`  out  1 each  sensor filter select: 00 red, 11 green, 01 blue.
- `red_freq`, `green_freq`, `blue_freq`  out  18 each  latched per-channel frequencies.
- `color`  out  2  00 none, 01 red, 10 green, 11 blue.
- `valid`  out  1  one-cycle pulse when `color` and the frequencies are updated.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky watchdog error; exists only with `COLOR_TIMEOUT_EN`.

## Operation
States:
- **IDLE**
  - `busy` = 0 and `cs_state` = 0.
  - `start` = 1 → SELECT with channel = RED.
- **SELECT**
  - Drive `s2`/`s3` for the current channel and count up to SETTLE_CYCLES.
  - Then → MEASURE.
- **MEASURE**
  - `cs_state` = 1.
  - On `flag_done` = 1, latch `frequency` into the current channel register in that same cycle, then → CAPTURE.
- **CAPTURE** (one cycle)
  - `cs_state` = 0 and `done_flag` = 1.
  - Channel order is RED → GREEN → BLUE. After BLUE → CLASSIFY; otherwise → SELECT with the next channel.
- **CLASSIFY** (one cycle)
  - Compute `color`, pulse `valid`, then → IDLE.

Classification rules:
- The winner must be strictly greater than both other channels; otherwise `color` = 00.
- A winner below `MIN_FREQ` also gives `color` = 00.
- Comparisons are unsigned 18-bit, with no scaling or normalisation.

Other rules:
- `done_flag` is high only in CAPTURE.
- `cs_state` is high only in MEASURE.
- Per-channel registers are overwritten only by captures.
- `color` changes only in the CLASSIFY cycle.
- `start` is ignored while `busy` = 1. A `start` held high through the return to IDLE begins a new run immediately.

Reset, synchronous to nothing (takes effect at once):
- State goes to IDLE.
- All outputs go to 0: `s2` = `s3` = 0, frequency registers, `color`, `valid`, `busy`, `cs_state`, `done_flag`, and `timeout_err`.
- Reset mid-run abandons the run. `cs_state` drops, so the counter clears itself.

## Timing
- `start` high in IDLE → `busy` = 1 on the next edge.
- Per channel: 1 + SETTLE_CYCLES cycles in SELECT, then MEASURE until `flag_done`, then 1 CAPTURE cycle.
- Counter latency is 500001 cycles after `cs_state` rises, giving about 3 × (SETTLE_CYCLES + 500003) + 1 cycles from `start` to `valid`.
- `valid` is asserted in the CLASSIFY cycle; `busy` deasserts on the following edge.
- `flag_done` is honoured only in MEASURE; a `flag_done` in any other state is ignored.
- The counter clears `frequency` when `cs_state` is low, so the capture must occur in the `flag_done` cycle, never later.

## Configuration
- `COLOR_TIMEOUT_EN` defined:
  - A watchdog counts cycles in MEASURE. Reaching TIMEOUT_CYCLES without `flag_done` stores 0 for that channel, sets `timeout_err`, and → CAPTURE.
  - `timeout_err` clears only on reset or on the next accepted `start`.
- `COLOR_TIMEOUT_EN` undefined:
  - No watchdog and no `timeout_err` port; MEASURE waits indefinitely.

## Test plan
Bench setup: `SETTLE_CYCLES` = 4, plus a behavioural counter model that returns a programmed value 20 cycles after `cs_state` rises.

- **Nominal red:** model returns R = 5000, G = 2000, B = 1500 → `s2s3` sequence 00, 11, 01. `red_freq` = 5000, `color` = 01, `valid` pulses once; `done_flag` pulses 3 times, each one cycle long.
- **Threshold and tie:**
  - R = 800, G = 600, B = 500 → `color` = 00.
  - R = G = 4000, B = 100 → `color` = 00.
- **Blue wins, ignored start:** B = 9000, others 1000, with `start` pulsed mid-run → `color` = 11, exactly one `valid`, no restart.
- **Reset mid-MEASURE on GREEN:** `reset_n` = 0 → same cycle, all outputs 0 and state IDLE. A subsequent run completes normally.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 50):** model never asserts `flag_done` on GREEN → `green_freq` = 0 and `timeout_err` = 1. The run still ends with `valid`, and the next `start` clears `timeout_err`.
- **Back-to-back:** `start` held high → a second run begins on the cycle after returning to IDLE, and `valid` pulses once per run.
